// File: rtl/wallace_multiplier_pipe_if.sv
// Handshake bundle for the pipelined Wallace multiplier: an operation channel
// toward the multiplier and a result channel back from it.
interface wallace_multiplier_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;

  // master issues operations and consumes results; slave is the multiplier
  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/wallace_multiplier_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, signed (Baugh-Wooley) or
// unsigned per operation, with a global stall and a tag carried alongside.
module wallace_multiplier_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  wallace_multiplier_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam int NA = NR + 2;

  function automatic logic [WIDTH*WIDTH-1:0] pp_matrix(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn
  );
    logic [WIDTH*WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        m[i*WIDTH+j] = (a[j] & b[i]) ^ (sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    return m;
  endfunction

  // Rows are combined three at a time with 3:2 counters per column; where a
  // column holds only two live bits the counter degenerates to a half adder.
  function automatic logic [2*PW-1:0] wallace_reduce(
    input logic [WIDTH*WIDTH-1:0] m,
    input logic                   sgn
  );
    logic [PW-1:0] cur [NA];
    logic [PW-1:0] nxt [NA];
    int n;
    int k;
    for (int r = 0; r < NA; r++) begin
      cur[r] = '0;
      nxt[r] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      cur[i] = {{WIDTH{1'b0}}, m[i*WIDTH +: WIDTH]} << i;
    end
    cur[WIDTH] = sgn ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
    n = NR;
    for (int l = 0; l < NR; l++) begin
      if (n > 2) begin
        k = 0;
        for (int r = 0; r < NA; r++) nxt[r] = '0;
        for (int g = 0; g < NR; g += 3) begin
          if (g + 2 < n) begin
            nxt[k]   = cur[g] ^ cur[g+1] ^ cur[g+2];
            nxt[k+1] = ((cur[g] & cur[g+1]) | (cur[g] & cur[g+2]) |
                        (cur[g+1] & cur[g+2])) << 1;
            k += 2;
          end else begin
            if (g < n) begin
              nxt[k] = cur[g];
              k += 1;
            end
            if (g + 1 < n) begin
              nxt[k] = cur[g+1];
              k += 1;
            end
          end
        end
        for (int r = 0; r < NA; r++) cur[r] = nxt[r];
        n = k;
      end
    end
    return {cur[1], cur[0]};
  endfunction

  logic                   adv;
  logic                   vld_p0, vld_p1, vld_p2;
  logic [WIDTH*WIDTH-1:0] pp_p0;
  logic                   sgn_p0;
  logic [TAG_W-1:0]       tag_p0, tag_p1, tag_p2;
  logic [PW-1:0]          sum_p1, carry_p1;
  logic [PW-1:0]          prod_p2;
  logic [WIDTH*WIDTH-1:0] pp_d;
  logic [PW-1:0]          sum_d, carry_d;

  assign adv          = !vld_p2 || bus.out_ready;
  assign bus.in_ready = adv;

  assign pp_d             = pp_matrix(bus.in_a, bus.in_b, bus.in_signed);
  assign {carry_d, sum_d} = wallace_reduce(pp_p0, sgn_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= bus.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S1: partial-product matrix; S2: reduced sum/carry rows
  always_ff @(posedge clk) begin
    if (adv) begin
      pp_p0    <= pp_d;
      sgn_p0   <= bus.in_signed;
      tag_p0   <= bus.in_tag;
      sum_p1   <= sum_d;
      carry_p1 <= carry_d;
      tag_p1   <= tag_p0;
    end
  end

  // S3: carry-propagate add; bubbles leave the presented result untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_p2 <= '0;
      tag_p2  <= '0;
    end else if (adv && vld_p1) begin
      prod_p2 <= sum_p1 + carry_p1;
      tag_p2  <= tag_p1;
    end
  end

  assign bus.out_valid   = vld_p2;
  assign bus.out_product = prod_p2;
  assign bus.out_tag     = tag_p2;
endmodule

// File: tb/tb_wallace_multiplier_pipe.sv
// Directed bench for the pipelined Wallace multiplier at WIDTH=8 and an
// exhaustive sweep at WIDTH=4.
module tb_wallace_multiplier_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wallace_multiplier_pipe_if #(.WIDTH(8), .TAG_W(4)) b8 ();
  wallace_multiplier_pipe_if #(.WIDTH(4), .TAG_W(9)) b4 ();

  wallace_multiplier_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  wallace_multiplier_pipe #(.WIDTH(4), .TAG_W(9)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [3:0]  t;
    logic [15:0] p;
    int          acc;
  } op8_t;

  op8_t pend_q[$];
  op8_t fly_q[$];

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sp;
    logic [15:0]        up;
    sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    up = {8'h00, a} * {8'h00, b};
    return s ? 16'(sp) : up;
  endfunction

  function automatic logic [7:0] model4(input logic [8:0] t);
    logic signed [7:0] sp;
    logic [7:0]        up;
    sp = $signed({{4{t[7]}}, t[7:4]}) * $signed({{4{t[3]}}, t[3:0]});
    up = {4'h0, t[7:4]} * {4'h0, t[3:0]};
    return t[8] ? 8'(sp) : up;
  endfunction

  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] p);
    op8_t o;
    o.a = a; o.b = b; o.s = s; o.t = t; o.p = p; o.acc = 0;
    pend_q.push_back(o);
  endtask

  task automatic run8(input string name, input bit bp);
    int   n_ops, got, cyc;
    op8_t o;
    op8_t e;
    n_ops = pend_q.size() + fly_q.size();
    got = 0;
    cyc = 0;
    while (got < n_ops && cyc < 300) begin
      @(negedge clk);
      b8.out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      b8.in_valid  = pend_q.size() > 0;
      if (pend_q.size() > 0) begin
        o = pend_q[0];
        b8.in_a = o.a; b8.in_b = o.b; b8.in_signed = o.s; b8.in_tag = o.t;
      end
      #1;
      if (bp) chk({name, "_in_ready"}, 32'(b8.in_ready), 32'(!b8.out_valid || b8.out_ready));
      if (b8.out_valid) begin
        if (fly_q.size() == 0) begin
          chk({name, "_unexpected_valid"}, 32'(b8.out_valid), 32'(0));
        end else begin
          e = fly_q[0];
          chk({name, "_prod"}, 32'(b8.out_product), 32'(e.p));
          chk({name, "_tag"}, 32'(b8.out_tag), 32'(e.t));
          if (b8.out_ready) begin
            void'(fly_q.pop_front());
            got++;
            if (!bp) chk({name, "_latency"}, 32'(cyc - e.acc), 32'(3));
          end
        end
      end
      if (b8.in_valid && b8.in_ready) begin
        o = pend_q.pop_front();
        o.acc = cyc;
        fly_q.push_back(o);
      end
      cyc++;
    end
    b8.in_valid = 1'b0;
    chk({name, "_count"}, 32'(got), 32'(n_ops));
  endtask

  task automatic run4();
    logic [8:0] q[$];
    logic [8:0] t;
    logic [8:0] e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 512 && cyc < 800) begin
      @(negedge clk);
      b4.out_ready = 1'b1;
      if (b4.out_valid) begin
        if (q.size() == 0) begin
          chk("w4_unexpected_valid", 32'(b4.out_valid), 32'(0));
        end else begin
          e = q.pop_front();
          got++;
          chk("w4_tag", 32'(b4.out_tag), 32'(e));
          chk("w4_prod", 32'(b4.out_product), 32'(model4(e)));
          if (e == 9'h0FF) chk("w4_u15x15", 32'(b4.out_product), 32'h0000_00E1);
          if (e == 9'h188) chk("w4_sm8xm8", 32'(b4.out_product), 32'h0000_0040);
          if (e == 9'h187) chk("w4_sm8x7", 32'(b4.out_product), 32'h0000_00C8);
        end
      end
      t = 9'(sent);
      b4.in_valid  = sent < 512;
      b4.in_a      = t[7:4];
      b4.in_b      = t[3:0];
      b4.in_signed = t[8];
      b4.in_tag    = t;
      #1;
      if (b4.in_valid && b4.in_ready) begin
        q.push_back(t);
        sent++;
      end
      cyc++;
    end
    b4.in_valid = 1'b0;
    chk("w4_count", 32'(got), 32'(512));
  endtask

  initial begin
    b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_signed = 1'b0; b8.in_tag = '0;
    b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_signed = 1'b0; b4.in_tag = '0;
    b4.out_ready = 1'b1;

    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(b8.out_valid), 32'(0));
    chk("rst_out_product", 32'(b8.out_product), 32'(0));
    chk("rst_out_tag", 32'(b8.out_tag), 32'(0));
    chk("rst_in_ready", 32'(b8.in_ready), 32'(1));
    rst_n = 1'b1;

    push8(8'd255, 8'd200 + 8'd55, 1'b0, 4'h1, 16'hFE01); run8("u255x255", 1'b0);
    push8(8'd0,   8'd200,         1'b0, 4'h2, 16'h0000); run8("u0x200", 1'b0);
    push8(8'd1,   8'd1,           1'b0, 4'h3, 16'h0001); run8("u1x1", 1'b0);
    @(negedge clk);
    chk("idle_out_valid", 32'(b8.out_valid), 32'(0));
    chk("idle_hold_prod", 32'(b8.out_product), 32'h0000_0001);
    chk("idle_hold_tag", 32'(b8.out_tag), 32'(3));

    push8(8'h80, 8'h80, 1'b1, 4'h4, 16'h4000);
    push8(8'hFF, 8'h01, 1'b1, 4'h5, 16'hFFFF);
    push8(8'h80, 8'h7F, 1'b1, 4'h6, 16'hC080);
    push8(8'h7F, 8'h7F, 1'b1, 4'h7, 16'h3F01);
    run8("signed", 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] a, b;
      a = 8'(i * 37 + 5);
      b = 8'(200 - i * 13);
      push8(a, b, 1'(i % 2), 4'(i), model8(a, b, 1'(i % 2)));
    end
    run8("stream", 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] a, b;
      a = 8'(250 - i * 29);
      b = 8'(i * 23 + 131);
      push8(a, b, 1'(i % 3 == 0), 4'(i + 3), model8(a, b, 1'(i % 3 == 0)));
    end
    run8("backpressure", 1'b1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b8.out_ready = 1'b1;
      b8.in_valid  = 1'b1;
      b8.in_a      = 8'(3 + i);
      b8.in_b      = 8'(5 + i);
      b8.in_signed = 1'b0;
      b8.in_tag    = 4'(9 + i);
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(b8.out_valid), 32'(0));
    chk("midrst_out_product", 32'(b8.out_product), 32'(0));
    chk("midrst_in_ready", 32'(b8.in_ready), 32'(1));
    push8(8'd7, 8'd6, 1'b0, 4'hA, 16'h002A);
    run8("after_reset", 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("after_reset_no_stale", 32'(b8.out_valid), 32'(0));
    end

    run4();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
